te_ack_collector: RTL

//   Return path of the TimingEngine fan-out. Sits in the most-on domain (PD_M1)
//   and issues radioReq to NUM_SINK less-on sink domains (PD_M2, PD_M3).

---
 rtl/te_ack_collector.sv | 104 ++++++++++
 1 files changed

// File: rtl/te_ack_collector.sv
// Return-path ack collector: issues radioReq to the sink domains and gathers
// four-phase acks, treating isolated sinks as already done.
module te_ack_collector #(
   parameter int NUM_SINK       = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic                ck,
   input  logic                arst,
   input  logic                pllSettled,
   input  logic                clrErr,
   input  logic [NUM_SINK-1:0] isolate,
   input  logic [NUM_SINK-1:0] sinkAck,
   output logic                radioReq,
   output logic                allAcked,
   output logic                timeoutErr,
   output logic [NUM_SINK-1:0] ackMask,
   output logic                busy
);

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, DONE, DRAIN, ERR
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic                pllPrev;
   logic                rise;
   logic [NUM_SINK-1:0] maskNext;
   logic                maskFull;
   logic                timeUp;
   logic                drained;

   assign rise     = pllSettled & ~pllPrev;
   assign maskNext = ackMask | sinkAck | isolate;
   assign maskFull = &maskNext;
   assign timeUp   = (count == CNT_W'(TIMEOUT_CYCLES - 1));
   // isolated sinks may hold a stale ack forever; never wait on them
   assign drained  = ((sinkAck & ~isolate) == '0);

   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         state      <= IDLE;
         count      <= '0;
         pllPrev    <= 1'b0;
         radioReq   <= 1'b0;
         allAcked   <= 1'b0;
         timeoutErr <= 1'b0;
         ackMask    <= '0;
         busy       <= 1'b0;
      end else begin
         pllPrev  <= pllSettled;
         allAcked <= 1'b0;
         if (clrErr) timeoutErr <= 1'b0;
         unique case (state)
            IDLE: begin
               radioReq <= 1'b0;
               ackMask  <= '0;
               if (rise) begin
                  state <= REQ;
                  busy  <= 1'b1;
               end
            end
            REQ: begin
               radioReq <= 1'b1;
               count    <= '0;
               ackMask  <= sinkAck | isolate;
               state    <= WAIT;
            end
            WAIT: begin
               radioReq <= 1'b1;
               ackMask  <= maskNext;
               // completion beats timeout when both land together
               if (maskFull) state <= DONE;
               else if (timeUp) state <= ERR;
               else count <= count + 1'b1;
            end
            DONE: begin
               allAcked <= 1'b1;
               radioReq <= 1'b0;
               state    <= DRAIN;
            end
            ERR: begin
               timeoutErr <= 1'b1;
               radioReq   <= 1'b0;
               state      <= DRAIN;
            end
            DRAIN: begin
               radioReq <= 1'b0;
               if (drained) begin
                  state   <= IDLE;
                  ackMask <= '0;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
